app_div_unit: RTL and testbench
===============================

// Module: app_div_unit
// PURPOSE
// - Approximate (Mitchell log-domain) 16-bit divider; inverse of the approximate log multiplier.
// - Computes log2 of each operand as characteristic + 15-bit fraction, subtracts, then takes the antilog.
// - Returns a Q16.16 scalar_t quotient.
// - Multi-cycle unit with valid/ready on both sides; sits beside the approximate multiplier in the execute path.
// PARAMETERS
// - CORR_VALUE      15'h0500        fraction correction applied on borrow (APP_DIV_CORR_EN only)
// - ZERO_DIV_VALUE  32'hFFFF_FFFF   quotient returned for divide-by-zero (sign ignored)
// PORTS
// - clk          in   1   clock, rising edge
// - reset        in   1   asynchronous, active-high
// - in_valid     in   1   operands valid
// - in_ready     out  1   unit idle, accepts operands
// - sign         in   1   1: operands are two's complement; 0: unsigned
// - dividend     in   16  numerator
// - divisor      in   16  denominator
// - out_valid    out  1   result valid, held until consumed
// - out_ready    in   1   consumer accepts result
// - quotient     out  32  Q16.16 result (scalar_t)
// - div_by_zero  out  1   divisor was 0; qualified by out_valid
// BEHAVIOUR
// - Reset: state=IDLE, in_ready=1, out_valid=0, quotient=0, div_by_zero=0. Applies at any time, aborts work in flight.
// - FSM states and transitions:
//   - IDLE -> LOG on in_valid&&in_ready; capture operands and sign.
//   - LOG -> DIFF -> ANTI unconditionally.
//   - ANTI -> DONE.
//   - DONE -> IDLE on out_ready.
// - in_ready=1 only in IDLE. out_valid=1 only in DONE.
// - Latency: out_valid rises 4 clk after the accept edge. Throughput 1 op per 5 clk minimum.
// - DONE with out_ready=0: quotient and div_by_zero are held stable, no new accept.
// - Leaving DONE: in_ready returns the cycle after the out_ready handshake; no same-cycle in/out overlap.
// - LOG state:
//   - If sign=1, each operand is replaced by its magnitude (-32768 -> 16'h8000).
//   - k = leading-one index (0..15).
//   - f = 15-bit fraction: (op << (15-k)), low 15 bits of the 16-bit result, i.e. bits below the leading one left-aligned.
//   - neg = sign && (dividend[15] ^ divisor[15]).
// - DIFF state: signed 6-bit char = ka - kb; 16-bit frac = fa - fb.
//   - On borrow: char -= 1 and frac += 2^15.
// - ANTI state:
//   - m = {1'b1, frac[14:0]}.
//   - s = char + 1, range -15..16.
//   - q = s>=0 ? {16'b0,m} << s : {16'b0,m} >> -s (zero-filled, truncated).
//   - If neg, q = ~q + 1.
// - Special cases, evaluated in LOG and forced through:
//   - divisor==0: quotient=ZERO_DIV_VALUE, div_by_zero=1.
//   - else dividend==0: quotient=0, div_by_zero=0.
//   - Latency is unchanged for both.
// - Inputs are ignored outside IDLE; X on dividend/divisor while in_valid=0 must not propagate.
// CONFIGURATION
// - APP_DIV_CORR_EN defined: on borrow in DIFF, frac = frac - CORR_VALUE, saturating at 0.
//   - No-borrow path is unchanged; reduces the Mitchell overestimate.
// - Undefined: pure Mitchell result, no correction logic instantiated.
// TESTING
// - sign=0, 100/10 -> quotient=32'h000A_8000, div_by_zero=0, out_valid 4 clk after accept.
// - sign=0, 3/4 -> 32'h0000_C000.
// - sign=1, -8/2 (16'hFFF8, 16'h0002) -> 32'hFFFC_0000.
// - 5/7: without APP_DIV_CORR_EN -> 32'h0000_C000; with it -> 32'h0000_BB00.
// - 5/0 -> 32'hFFFF_FFFF, div_by_zero=1; then 0/9 -> 32'h0, div_by_zero=0.
// - Handshake and reset:
//   - Hold out_ready=0 for 10 clk: result stable, in_ready=0.
//   - Assert reset in DIFF: out_valid stays 0, in_ready=1 next cycle.
//   - Next op 8/2 -> 32'h0004_0000.

Source files
------------

// File: rtl/app_div_unit.sv
// Approximate (Mitchell log-domain) 16-bit divider producing a Q16.16 quotient.
// Latency: out_valid rises on the 4th rising edge counting the accept edge as the first; one op per 5 clk at best.
// Backpressure: DONE holds quotient/div_by_zero until out_ready; in_ready is high only in IDLE.
// Optional feature: define APP_DIV_CORR_EN to apply a saturating fraction correction on borrow.
module app_div_unit #(
  parameter logic [31:0] ZERO_DIV_VALUE = 32'hFFFF_FFFF
`ifdef APP_DIV_CORR_EN
  , parameter logic [14:0] CORR_VALUE = 15'h0500
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOG  = 3'd1,
    DIFF = 3'd2,
    ANTI = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state;

  // captured operands
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_sign;

  // log-domain terms
  logic [3:0]  ka;
  logic [3:0]  kb;
  logic [14:0] fa;
  logic [14:0] fb;
  logic        neg;
  logic        zdiv;
  logic        znum;

  // difference of logs
  logic signed [5:0] chr;
  logic [14:0]       frac;

  // Leading-one index; an all-zero value yields 0 (zero operands take the special path).
  function automatic logic [3:0] lead_one(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = i[3:0];
    end
    return idx;
  endfunction

  // Bits below the leading one, left-aligned into 15 bits.
  function automatic logic [14:0] frac_of(input logic [15:0] v, input logic [3:0] k);
    logic [15:0] t;
    t = v << (4'd15 - k);
    return t[14:0];
  endfunction

  logic [15:0]       mag_a;
  logic [15:0]       mag_b;
  logic [3:0]        ka_c;
  logic [3:0]        kb_c;
  logic [14:0]       fa_c;
  logic [14:0]       fb_c;
  logic [15:0]       fdiff;
  logic              borrow;
  logic signed [5:0] chr_c;
  logic [14:0]       frac_c;
  logic signed [5:0] shift_s;
  logic [5:0]        shift_n;
  logic [31:0]       m_wide;
  logic [31:0]       q_c;

  // Per-stage combinational datapath feeding the FSM registers.
  always_comb begin
    mag_a   = (op_sign && op_a[15]) ? (~op_a + 16'd1) : op_a;
    mag_b   = (op_sign && op_b[15]) ? (~op_b + 16'd1) : op_b;
    ka_c    = lead_one(mag_a);
    kb_c    = lead_one(mag_b);
    fa_c    = frac_of(mag_a, ka_c);
    fb_c    = frac_of(mag_b, kb_c);

    // Adding 2^15 on borrow only clears bit 15, so the low 15 bits are already the fraction.
    fdiff   = {1'b0, fa} - {1'b0, fb};
    borrow  = fdiff[15];
    chr_c   = $signed({2'b00, ka}) - $signed({2'b00, kb}) - $signed({5'b0, borrow});
`ifdef APP_DIV_CORR_EN
    if (borrow) begin
      frac_c = (fdiff[14:0] > CORR_VALUE) ? (fdiff[14:0] - CORR_VALUE) : 15'd0;
    end else begin
      frac_c = fdiff[14:0];
    end
`else
    frac_c  = fdiff[14:0];
`endif

    // Mantissa is Q1.15, result is Q16.16, hence the extra +1 on the shift.
    shift_s = chr + 6'sd1;
    shift_n = 6'd0 - shift_s;
    m_wide  = {16'b0, 1'b1, frac};
    if (!shift_s[5]) begin
      q_c = m_wide << shift_s[4:0];
    end else begin
      q_c = m_wide >> shift_n[4:0];
    end
    if (neg) begin
      q_c = ~q_c + 32'd1;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= 32'd0;
      div_by_zero <= 1'b0;
      op_a        <= 16'd0;
      op_b        <= 16'd0;
      op_sign     <= 1'b0;
      ka          <= 4'd0;
      kb          <= 4'd0;
      fa          <= 15'd0;
      fb          <= 15'd0;
      neg         <= 1'b0;
      zdiv        <= 1'b0;
      znum        <= 1'b0;
      chr         <= 6'sd0;
      frac        <= 15'd0;
    end else begin
      case (state)
        IDLE: begin
          // Operands are only sampled on a real accept, so idle-time X never enters the datapath.
          if (in_valid) begin
            op_a     <= dividend;
            op_b     <= divisor;
            op_sign  <= sign;
            in_ready <= 1'b0;
            state    <= LOG;
          end
        end
        LOG: begin
          ka    <= ka_c;
          kb    <= kb_c;
          fa    <= fa_c;
          fb    <= fb_c;
          neg   <= op_sign && (op_a[15] ^ op_b[15]);
          zdiv  <= (op_b == 16'd0);
          znum  <= (op_a == 16'd0);
          state <= DIFF;
        end
        DIFF: begin
          chr   <= chr_c;
          frac  <= frac_c;
          state <= ANTI;
        end
        ANTI: begin
          // Special cases ride through the pipeline and override here to keep latency fixed.
          if (zdiv) begin
            quotient <= ZERO_DIV_VALUE;
          end else if (znum) begin
            quotient <= 32'd0;
          end else begin
            quotient <= q_c;
          end
          div_by_zero <= zdiv;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_app_div_unit.sv
// Directed bench for app_div_unit: Mitchell quotients, special cases, handshake and reset abort.
module tb_app_div_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic        div_by_zero;

  int checks;
  int failures;

  app_div_unit dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign        (sign),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation; lat counts rising edges from the accept edge (inclusive) to out_valid.
  task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic release_result,
                        output logic [31:0] q, output logic z, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    sign     = s;
    dividend = a;
    divisor  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 'x;
    divisor  = 'x;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    q = quotient;
    z = div_by_zero;
    if (release_result) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (quotient !== 32'd0) begin
      failures++;
      $display("FAIL reset_quotient got=%h want=00000000", quotient);
    end
    checks++;
    if (div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_div_by_zero got=%b want=0", div_by_zero);
    end
  endtask

  task automatic test_basic();
    logic [31:0] q;
    logic        z;
    int          lat;
    run_op(1'b0, 16'd100, 16'd10, 1'b1, q, z, lat);
    checks++;
    if (q !== 32'h000A_8000) begin
      failures++;
      $display("FAIL div_100_10 got=%h want=000a8000", q);
    end
    checks++;
    if (z !== 1'b0) begin
      failures++;
      $display("FAIL div_100_10_dbz got=%b want=0", z);
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL latency got=%0d want=4", lat);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] q;
    logic        z;
    int          lat;
    logic [31:0] exp57;
`ifdef APP_DIV_CORR_EN
    exp57 = 32'h0000_BB00;
`else
    exp57 = 32'h0000_C000;
`endif
    run_op(1'b0, 16'd3, 16'd4, 1'b1, q, z, lat);
    checks++;
    if (q !== 32'h0000_C000) begin
      failures++;
      $display("FAIL div_3_4 got=%h want=0000c000", q);
    end
    run_op(1'b1, 16'hFFF8, 16'h0002, 1'b1, q, z, lat);
    checks++;
    if (q !== 32'hFFFC_0000) begin
      failures++;
      $display("FAIL div_m8_2 got=%h want=fffc0000", q);
    end
    run_op(1'b0, 16'd5, 16'd7, 1'b1, q, z, lat);
    checks++;
    if (q !== exp57) begin
      failures++;
      $display("FAIL div_5_7 got=%h want=%h", q, exp57);
    end
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b1, q, z, lat);
    checks++;
    if (q !== 32'hFFFF_0000) begin
      failures++;
      $display("FAIL div_max_1 got=%h want=ffff0000", q);
    end
    run_op(1'b0, 16'h0001, 16'hFFFF, 1'b1, q, z, lat);
    checks++;
    if (q !== 32'h0000_0001) begin
      failures++;
      $display("FAIL div_1_max got=%h want=00000001", q);
    end
    run_op(1'b1, 16'h8000, 16'h0001, 1'b1, q, z, lat);
    checks++;
    if (q !== 32'h8000_0000) begin
      failures++;
      $display("FAIL div_min_1 got=%h want=80000000", q);
    end
  endtask

  task automatic test_special();
    logic [31:0] q;
    logic        z;
    int          lat;
    run_op(1'b0, 16'd5, 16'd0, 1'b1, q, z, lat);
    checks++;
    if (q !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL div_by_0_q got=%h want=ffffffff", q);
    end
    checks++;
    if (z !== 1'b1) begin
      failures++;
      $display("FAIL div_by_0_flag got=%b want=1", z);
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL div_by_0_latency got=%0d want=4", lat);
    end
    run_op(1'b0, 16'd0, 16'd9, 1'b1, q, z, lat);
    checks++;
    if (q !== 32'h0) begin
      failures++;
      $display("FAIL zero_num_q got=%h want=00000000", q);
    end
    checks++;
    if (z !== 1'b0) begin
      failures++;
      $display("FAIL zero_num_flag got=%b want=0", z);
    end
  endtask

  task automatic test_hold();
    logic [31:0] q;
    logic        z;
    int          lat;
    int          n;
    run_op(1'b0, 16'd12, 16'd3, 1'b0, q, z, lat);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (quotient !== 32'h0004_0000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d got q=%h ov=%b ir=%b want q=00040000 ov=1 ir=0",
                 i, quotient, out_valid, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] q;
    logic        z;
    int          lat;
    logic        seen_valid;
    @(negedge clk);
    in_valid = 1'b1;
    sign     = 1'b0;
    dividend = 16'd100;
    divisor  = 16'd10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_no_result got=%b want=0", seen_valid);
    end
    run_op(1'b0, 16'd8, 16'd2, 1'b1, q, z, lat);
    checks++;
    if (q !== 32'h0004_0000) begin
      failures++;
      $display("FAIL after_reset_8_2 got=%h want=00040000", q);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign      = 1'b0;
    dividend  = 16'd0;
    divisor   = 16'd0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_basic();
    test_vectors();
    test_special();
    test_hold();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
